// File: rtl/mem_resp_pkg.sv
// Shared types and widths for the MEM-stage data-memory responder.
// Imported by the responder top and its storage array.
package mem_resp_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  localparam logic [ADDR_W-1:0] IO_ADDR_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } state_t;

endpackage

// File: rtl/mem_resp_storage.sv
// DEPTH x DATA_W register-file storage: one synchronous write port,
// one combinational read port, every word cleared by the async reset.
module mem_resp_storage
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int IDX_W = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/mem_responder.sv
// Responder for the CPU MEM-stage data access: storage array plus one
// memory-mapped output register, fixed wait states, four-phase handshake.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int                DEPTH       = 32,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [DATA_W-1:0] io_out
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  CNT_START = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_is_mem;
  logic              acc_is_io;
  logic              acc_err;
  logic [DATA_W-1:0] acc_rdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;
  logic              enter_ack;

  // With zero wait states the access commits straight from IDLE, so the
  // live request fields stand in for the not-yet-latched copies.
  always_comb begin
    acc_write = lat_write;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    if (state == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
  end

  always_comb begin
    acc_is_mem = (acc_addr < DEPTH_A);
    acc_is_io  = (acc_addr == IO_ADDR);
    acc_err    = !acc_is_mem && !acc_is_io;
    acc_rdata  = '0;
    if (!acc_write) begin
      if (acc_is_mem) begin
        acc_rdata = mem_rdata;
      end else if (acc_is_io) begin
        acc_rdata = io_out;
      end
    end
  end

  assign enter_ack = req_valid &&
                     (((state == IDLE) && (WAIT_CYCLES == 0)) ||
                      ((state == BUSY) && (cnt == '0)));
  assign mem_we    = enter_ack && acc_write && acc_is_mem;

  mem_resp_storage #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_storage (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (mem_we),
    .wr_idx  (acc_addr[IDX_W-1:0]),
    .wr_data (acc_wdata),
    .rd_idx  (acc_addr[IDX_W-1:0]),
    .rd_data (mem_rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      io_out    <= '0;
    end else begin
      if (enter_ack) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= acc_rdata;
        rsp_err   <= acc_err;
        if (acc_write && acc_is_io) begin
          io_out <= acc_wdata;
        end
      end
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            if (WAIT_CYCLES == 0) begin
              state <= ACK;
            end else begin
              state <= BUSY;
              cnt   <= CNT_START;
            end
          end
        end
        BUSY: begin
          if (!req_valid) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == '0) begin
            state <= ACK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACK: begin
          if (!req_valid) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
